// File: rtl/hash_verifier.sv
// Checks submitted hash attempts against the live hash (or the one just before it),
// counting consecutive failures and holding a timed lockout after too many.
module hash_verifier #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cur_hash,
    input  logic        try_valid,
    input  logic [15:0] try_hash,
    output logic        try_ready,
    output logic        grant,
    output logic        deny,
    output logic        locked,
    output logic [3:0]  fail_count
);

    typedef enum logic [1:0] {IDLE, CHECK, LOCKED} state_t;

    localparam logic [4:0] MAX_FAILS_W = 5'(MAX_FAILS);
    localparam logic [3:0] MAX_FAILS_C = 4'(MAX_FAILS);
    localparam logic [7:0] LOCK_INIT   = 8'(LOCK_CYCLES);

    state_t      state;
    logic [15:0] attempt_reg;
    logic [15:0] last_seen;
    logic [15:0] prev_hash;
    logic        prev_valid;
    logic        seen_loaded;
    logic [7:0]  lock_ctr;
    logic        match;
    logic [4:0]  next_fails;

    assign try_ready  = rst_n && (state == IDLE);
    assign match      = (attempt_reg == cur_hash) || (prev_valid && (attempt_reg == prev_hash));
    assign next_fails = {1'b0, fail_count} + 5'd1;

    // The reset value of last_seen is not a real hash, so the first change only loads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen   <= 16'h0000;
            prev_hash   <= 16'h0000;
            prev_valid  <= 1'b0;
            seen_loaded <= 1'b0;
        end else if (cur_hash != last_seen) begin
            last_seen   <= cur_hash;
            seen_loaded <= 1'b1;
            if (seen_loaded) begin
                prev_hash  <= last_seen;
                prev_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            attempt_reg <= 16'h0000;
            grant       <= 1'b0;
            deny        <= 1'b0;
            locked      <= 1'b0;
            fail_count  <= 4'd0;
            lock_ctr    <= 8'd0;
        end else begin
            grant <= 1'b0;
            deny  <= 1'b0;
            case (state)
                IDLE: begin
                    if (try_valid) begin
                        attempt_reg <= try_hash;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (match) begin
                        grant      <= 1'b1;
                        fail_count <= 4'd0;
                        state      <= IDLE;
                    end else if (next_fails < MAX_FAILS_W) begin
                        deny       <= 1'b1;
                        fail_count <= next_fails[3:0];
                        state      <= IDLE;
                    end else begin
                        deny       <= 1'b1;
                        fail_count <= MAX_FAILS_C;
                        locked     <= 1'b1;
                        lock_ctr   <= LOCK_INIT;
                        state      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (lock_ctr <= 8'd1) begin
                        locked     <= 1'b0;
                        fail_count <= 4'd0;
                        lock_ctr   <= 8'd0;
                        state      <= IDLE;
                    end else begin
                        lock_ctr <= lock_ctr - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_verifier.sv
// Directed bench for hash_verifier: a history-queue model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_hash_verifier;

    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 16;

    logic        clk;
    logic        rst_n;
    logic [15:0] cur_hash;
    logic        try_valid;
    logic [15:0] try_hash;
    logic        try_ready;
    logic        grant;
    logic        deny;
    logic        locked;
    logic [3:0]  fail_count;

    int n_checks = 0;
    int n_pass   = 0;

    hash_verifier #(.MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cur_hash(cur_hash),
        .try_valid(try_valid),
        .try_hash(try_hash),
        .try_ready(try_ready),
        .grant(grant),
        .deny(deny),
        .locked(locked),
        .fail_count(fail_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    endtask

    // Model: the accepted window is the live hash plus the previous distinct value seen,
    // once at least two distinct values have actually arrived since reset.
    logic [15:0] hist[$];
    bit          m_busy;
    logic [15:0] m_attempt;
    int          m_fails;
    int          m_lock_left;
    bit          m_grant;
    bit          m_deny;
    bit          hit;
    logic [15:0] newest;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_busy      = 0;
            m_attempt   = 16'h0;
            m_fails     = 0;
            m_lock_left = 0;
            m_grant     = 0;
            m_deny      = 0;
        end else begin
            m_grant = 0;
            m_deny  = 0;
            if (m_lock_left > 0) begin
                m_lock_left--;
                if (m_lock_left == 0) m_fails = 0;
            end else if (m_busy) begin
                m_busy = 0;
                hit = (m_attempt == cur_hash) ||
                      (hist.size() >= 2 && m_attempt == hist[hist.size()-2]);
                if (hit) begin
                    m_grant = 1;
                    m_fails = 0;
                end else begin
                    m_deny = 1;
                    m_fails++;
                    if (m_fails >= MAX_FAILS) m_lock_left = LOCK_CYCLES;
                end
            end else if (try_valid) begin
                m_busy    = 1;
                m_attempt = try_hash;
            end
            newest = (hist.size() == 0) ? 16'h0000 : hist[hist.size()-1];
            if (cur_hash != newest) hist.push_back(cur_hash);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model grant", {15'd0, grant}, {15'd0, m_grant});
            checkOutput("model deny", {15'd0, deny}, {15'd0, m_deny});
            checkOutput("model locked", {15'd0, locked}, {15'd0, m_lock_left > 0});
            checkOutput("model fail_count", {12'd0, fail_count}, 16'(m_fails));
            checkOutput("model try_ready", {15'd0, try_ready}, {15'd0, !m_busy && m_lock_left == 0});
        end
    end

    // Submits one attempt and samples the decision cycle's outputs.
    task automatic applyStimulus(input logic [15:0] h, output logic g, output logic d, output logic [3:0] fc);
        int waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!try_ready && waited < 40);
        if (!try_ready) checkOutput("ready timeout", {15'd0, try_ready}, 16'd1);
        try_valid = 1'b1;
        try_hash  = h;
        @(posedge clk);
        #1;
        try_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        g  = grant;
        d  = deny;
        fc = fail_count;
    endtask

    task automatic pulseReset(input logic [15:0] h);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        cur_hash = h;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic       g, d;
    logic [3:0] fc;
    int         lock_len;
    bit         pulse_in_lock;

    initial begin
        rst_n     = 1'b0;
        cur_hash  = 16'h0000;
        try_valid = 1'b0;
        try_hash  = 16'h0000;
        #12;
        checkOutput("reset try_ready", {15'd0, try_ready}, 16'd0);
        checkOutput("reset locked", {15'd0, locked}, 16'd0);
        checkOutput("reset fail_count", {12'd0, fail_count}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while an attempt is waiting for its check.
        @(posedge clk);
        #1;
        try_valid = 1'b1;
        try_hash  = 16'h1111;
        @(posedge clk);
        #1;
        try_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset grant", {15'd0, grant}, 16'd0);
        checkOutput("midreset deny", {15'd0, deny}, 16'd0);
        checkOutput("midreset try_ready", {15'd0, try_ready}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset grant", {15'd0, grant}, 16'd0);
        checkOutput("post-reset deny", {15'd0, deny}, 16'd0);
        checkOutput("post-reset try_ready", {15'd0, try_ready}, 16'd1);

        // Correct attempt, grant is a single-cycle pulse.
        cur_hash = 16'hA5C3;
        repeat (2) @(negedge clk);
        applyStimulus(16'hA5C3, g, d, fc);
        checkOutput("correct grant", {15'd0, g}, 16'd1);
        checkOutput("correct deny", {15'd0, d}, 16'd0);
        checkOutput("correct fail_count", {12'd0, fc}, 16'd0);
        @(negedge clk);
        checkOutput("correct grant width", {15'd0, grant}, 16'd0);

        // Roll-over window: previous hash accepted, two-old hash rejected.
        cur_hash = 16'h1234;
        repeat (2) @(negedge clk);
        cur_hash = 16'h5678;
        repeat (2) @(negedge clk);
        applyStimulus(16'h1234, g, d, fc);
        checkOutput("window prev grant", {15'd0, g}, 16'd1);
        cur_hash = 16'h9ABC;
        repeat (2) @(negedge clk);
        applyStimulus(16'h1234, g, d, fc);
        checkOutput("window stale deny", {15'd0, d}, 16'd1);
        checkOutput("window stale fail_count", {12'd0, fc}, 16'd1);

        // A zero attempt must not match the reset value of the window.
        pulseReset(16'h00FF);
        applyStimulus(16'h0000, g, d, fc);
        checkOutput("spurious zero deny", {15'd0, d}, 16'd1);
        checkOutput("spurious zero grant", {15'd0, g}, 16'd0);

        // Three failures lock the block for LOCK_CYCLES cycles.
        pulseReset(16'hBEEF);
        applyStimulus(16'h0000, g, d, fc);
        checkOutput("lock try1 fail_count", {12'd0, fc}, 16'd1);
        applyStimulus(16'h0000, g, d, fc);
        checkOutput("lock try2 fail_count", {12'd0, fc}, 16'd2);
        applyStimulus(16'h0000, g, d, fc);
        checkOutput("lock try3 deny", {15'd0, d}, 16'd1);
        checkOutput("lock try3 fail_count", {12'd0, fc}, 16'd3);
        checkOutput("lock entered", {15'd0, locked}, 16'd1);
        checkOutput("lock try_ready", {15'd0, try_ready}, 16'd0);
        lock_len      = locked ? 1 : 0;
        pulse_in_lock = 1'b0;
        try_valid     = 1'b1;
        try_hash      = 16'hBEEF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 5) try_valid = 1'b0;
            if (grant || deny) pulse_in_lock = 1'b1;
            if (!locked) break;
            lock_len++;
        end
        try_valid = 1'b0;
        checkOutput("lock length", 16'(lock_len), 16'(LOCK_CYCLES));
        checkOutput("lock no pulse", {15'd0, pulse_in_lock}, 16'd0);
        checkOutput("lock exit fail_count", {12'd0, fail_count}, 16'd0);
        applyStimulus(16'hBEEF, g, d, fc);
        checkOutput("after lock grant", {15'd0, g}, 16'd1);

        // Success clears the failure count before lockout is reached.
        applyStimulus(16'h0000, g, d, fc);
        applyStimulus(16'h0000, g, d, fc);
        checkOutput("two fails fail_count", {12'd0, fc}, 16'd2);
        applyStimulus(16'hBEEF, g, d, fc);
        checkOutput("recover grant", {15'd0, g}, 16'd1);
        checkOutput("recover fail_count", {12'd0, fc}, 16'd0);
        checkOutput("recover locked", {15'd0, locked}, 16'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
